max_search_unit: RTL

- Four-lane down-counting search datapath plus a controlling FSM.
- Sits directly around the end-signal generator. It drives the four per-PU zero flags into that generator and consumes the returned end_signal.
- Loads four unsigned operands and decrements every nonzero lane once per cycle until exactly one lane stays nonzero. It then reports that lane as the maximum.
- Handles the equal-maximum case (all lanes reach zero together) as a tie.

---
 rtl/max_search_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/max_search_unit.sv
// max_search_unit: four-lane down-counting maximum search with FSM; optional cycle counter under MSU_CYCLE_COUNT_EN
module max_search_unit #(
  parameter int WIDTH = 8
`ifdef MSU_CYCLE_COUNT_EN
  , parameter int CNT_WIDTH = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in0,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  input  logic [WIDTH-1:0] data_in3,
  input  logic             end_signal,
  output logic             PU0_zero,
  output logic             PU1_zero,
  output logic             PU2_zero,
  output logic             PU3_zero,
  output logic             busy,
  output logic             done,
  output logic             tie,
  output logic [1:0]       winner,
  output logic [WIDTH-1:0] max_value
`ifdef MSU_CYCLE_COUNT_EN
  , output logic [CNT_WIDTH-1:0] cycle_count
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] cnt [4];
  logic [WIDTH-1:0] shadow [4];
  logic [3:0] nz;
  logic [1:0] sel;
  assign nz = {cnt[3] != '0, cnt[2] != '0, cnt[1] != '0, cnt[0] != '0};
  assign {PU3_zero, PU2_zero, PU1_zero, PU0_zero} = ~nz;
  // index of the surviving nonzero lane when the generator reports a single survivor
  always_comb sel = nz[3] ? 2'd3 : nz[2] ? 2'd2 : nz[1] ? 2'd1 : 2'd0;
  // search control, lane counters and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
        shadow[i] <= '0;
      end
      busy <= 1'b0;
      done <= 1'b0;
      tie <= 1'b0;
      winner <= 2'd0;
      max_value <= '0;
`ifdef MSU_CYCLE_COUNT_EN
      cycle_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt[0] <= data_in0;
            cnt[1] <= data_in1;
            cnt[2] <= data_in2;
            cnt[3] <= data_in3;
            shadow[0] <= data_in0;
            shadow[1] <= data_in1;
            shadow[2] <= data_in2;
            shadow[3] <= data_in3;
            tie <= 1'b0;
            busy <= 1'b1;
            state <= RUN;
`ifdef MSU_CYCLE_COUNT_EN
            cycle_count <= '0;
`endif
          end
        end
        RUN: begin
          if (end_signal) begin
            winner <= sel;
            max_value <= shadow[sel];
            tie <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end else if (nz == 4'd0) begin
            winner <= 2'd0;
            max_value <= '0;
            tie <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end else begin
            for (int i = 0; i < 4; i++) cnt[i] <= cnt[i] - WIDTH'(nz[i]);
`ifdef MSU_CYCLE_COUNT_EN
            cycle_count <= cycle_count + CNT_WIDTH'(cycle_count != '1);
`endif
          end
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
